combo_lock_ctrl: RTL and testbench

- Parametrised keypad combination-lock controller for the MAX10 board.
- Takes raw 4-bit keypad codes plus an active-low valid strobe, synchronises them and converts each press into a single-cycle key event.
- Runs a set/lock/unlock FSM with configurable code length.
- Adds a failed-attempt counter and a timed lockout penalty; drives digit/status outputs to the display and LED logic.

---
 rtl/combo_lock_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_combo_lock_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/combo_lock_ctrl.sv
// Keypad combination lock: input sync, one-event-per-press capture, set/lock/unlock FSM, lockout.
// Optional idle auto-relock is enabled by defining COMBO_LOCK_AUTO_RELOCK_EN.
module combo_lock_ctrl #(
  parameter int          NUM_DIGITS     = 6,
  parameter int          MAX_TRIES      = 3,
  parameter int          LOCKOUT_CYCLES = 250000000,
  parameter logic [3:0]  CLR_KEY        = 4'hF,
  parameter logic [3:0]  ENTER_KEY      = 4'hE
`ifdef COMBO_LOCK_AUTO_RELOCK_EN
  ,
  parameter int          RELOCK_CYCLES  = 500000000
`endif
) (
  input  logic                              MAX10_CLK1_50,
  input  logic                              nreset,
  input  logic [3:0]                        key_code,
  input  logic                              key_valid_n,
  output logic [4*NUM_DIGITS-1:0]           attempt,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_count,
  output logic                              locked,
  output logic                              set_mode,
  output logic                              lockout,
  output logic [3:0]                        fail_count,
  output logic                              unlock_pulse,
  output logic                              error_pulse
);

  localparam int             AW   = 4 * NUM_DIGITS;
  localparam int             CW   = $clog2(NUM_DIGITS + 1);
  localparam int             TW   = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [CW-1:0]  FULL = CW'(NUM_DIGITS);
  localparam logic [3:0]     MAXF = 4'(MAX_TRIES);

  typedef enum logic [1:0] {
    CAP_IDLE,
    CAP_CAPTURE,
    CAP_WAIT_RELEASE
  } cap_state_t;

  typedef enum logic [1:0] {
    ST_UNLOCKED,
    ST_LOCKED,
    ST_LOCKOUT
  } lock_state_t;

  logic [3:0]  code_meta;
  logic [3:0]  code_sync;
  logic        vn_meta;
  logic        vn_sync;

  cap_state_t  cap_state;
  cap_state_t  cap_next;
  logic        key_event;
  logic [3:0]  key_value;

  lock_state_t state;
  lock_state_t state_next;
  logic [AW-1:0] code;
  logic [AW-1:0] code_next;
  logic [AW-1:0] attempt_next;
  logic [CW-1:0] count_next;
  logic [3:0]    fail_next;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_next;
  logic          unlock_next;
  logic          error_next;
  logic          entry_ok;
  logic          submit;

  // Two-flop synchronisers; valid_n idles high so a key held through reset is seen as a fresh press.
  always_ff @(posedge MAX10_CLK1_50 or negedge nreset) begin
    if (!nreset) begin
      code_meta <= '0;
      code_sync <= '0;
      vn_meta   <= 1'b1;
      vn_sync   <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      code_meta <= key_code;
      code_sync <= code_meta;
      vn_meta   <= key_valid_n;
      vn_sync   <= vn_meta;
    end
  end

  always_ff @(posedge MAX10_CLK1_50 or negedge nreset) begin
    if (!nreset) begin
      cap_state <= CAP_IDLE;
      key_event <= 1'b0;
      key_value <= '0;
    end else begin
      cap_state <= cap_next;
      key_event <= (cap_state == CAP_CAPTURE);
      if (cap_state == CAP_CAPTURE) begin
        key_value <= code_sync;
      end
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
    cap_next = cap_state;
    case (cap_state)
      CAP_IDLE:         if (!vn_sync) cap_next = CAP_CAPTURE;
      CAP_CAPTURE:      cap_next = CAP_WAIT_RELEASE;
      CAP_WAIT_RELEASE: if (vn_sync) cap_next = CAP_IDLE;
      default:          cap_next = CAP_IDLE;
    endcase
  end

`ifdef COMBO_LOCK_AUTO_RELOCK_EN
  localparam int RW = (RELOCK_CYCLES > 1) ? $clog2(RELOCK_CYCLES) : 1;

  logic [RW-1:0] idle_cnt;
  logic [RW-1:0] idle_next;
  logic          code_set;
  logic          code_set_next;

  always_ff @(posedge MAX10_CLK1_50 or negedge nreset) begin
    if (!nreset) begin
      idle_cnt <= '0;
      code_set <= 1'b0;
    end else begin
      idle_cnt <= idle_next;
      code_set <= code_set_next;
    end
  end
`endif

  always_comb begin
    state_next   = state;
    code_next    = code;
    attempt_next = attempt;
    count_next   = digit_count;
    fail_next    = fail_count;
    timer_next   = timer;
    unlock_next  = 1'b0;
    error_next   = 1'b0;

    entry_ok = key_event && (state != ST_LOCKOUT);
    submit   = entry_ok && (key_value == ENTER_KEY) && (digit_count == FULL);

    if (state == ST_LOCKOUT) begin
      if (timer == '0) begin
        state_next = ST_LOCKED;
        fail_next  = '0;
      end else begin
        timer_next = timer - 1'b1;
      end
    end

    if (entry_ok) begin
      if (key_value == CLR_KEY) begin
        attempt_next = '0;
        count_next   = '0;
      end else if (submit) begin
        attempt_next = '0;
        count_next   = '0;
        if (state == ST_UNLOCKED) begin
          code_next  = attempt;
          state_next = ST_LOCKED;
          fail_next  = '0;
        end else if (attempt == code) begin
          unlock_next = 1'b1;
          fail_next   = '0;
          state_next  = ST_UNLOCKED;
        end else begin
          error_next = 1'b1;
          fail_next  = (fail_count >= MAXF) ? MAXF : fail_count + 4'd1;
          if (fail_next == MAXF) begin
            state_next = ST_LOCKOUT;
            timer_next = TW'(LOCKOUT_CYCLES - 1);
          end
        end
      end else if (digit_count < FULL) begin
        // Slot 0 sits in the MSBs so the entry reads left to right on the display.
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (digit_count == CW'(i)) begin
            attempt_next[AW-4-4*i +: 4] = key_value;
          end
        end
        count_next = digit_count + 1'b1;
      end
    end

`ifdef COMBO_LOCK_AUTO_RELOCK_EN
    code_set_next = code_set | (submit && (state == ST_UNLOCKED));
    idle_next     = '0;
    if ((state == ST_UNLOCKED) && code_set) begin
      if (key_event) begin
        idle_next = '0;
      end else if (idle_cnt == RW'(RELOCK_CYCLES - 1)) begin
        // Counter parks at terminal count while a partial entry blocks the relock.
        idle_next = idle_cnt;
        if (digit_count == '0) begin
          state_next = ST_LOCKED;
        end
      end else begin
        idle_next = idle_cnt + 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge MAX10_CLK1_50 or negedge nreset) begin
    if (!nreset) begin
      state        <= ST_UNLOCKED;
      // NOTE: the stored code is a register bank, not a memory, so it takes the async reset like all other state.
      code         <= '1;
      attempt      <= '0;
      digit_count  <= '0;
      fail_count   <= '0;
      timer        <= '0;
      unlock_pulse <= 1'b0;
      error_pulse  <= 1'b0;
    end else begin
      state        <= state_next;
      code         <= code_next;
      attempt      <= attempt_next;
      digit_count  <= count_next;
      fail_count   <= fail_next;
      timer        <= timer_next;
      unlock_pulse <= unlock_next;
      error_pulse  <= error_next;
    end
  end

  assign locked   = (state != ST_UNLOCKED);
  assign set_mode = (state == ST_UNLOCKED);
  assign lockout  = (state == ST_LOCKOUT);

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Scoreboard bench for combo_lock_ctrl: stimulus queues expected output snapshots with their arrival
// cycle; a negedge monitor pops one entry every time any output changes.
module tb_combo_lock_ctrl;

  localparam int N  = 4;
  localparam int MT = 2;
  localparam int LC = 20;
  localparam int CW = $clog2(N + 1);

  localparam int UNL = 0;
  localparam int LCK = 1;
  localparam int OUT = 2;

  typedef struct packed {
    logic [4*N-1:0] attempt;
    logic [CW-1:0]  count;
    logic           locked;
    logic           set_mode;
    logic           lockout;
    logic [3:0]     fail;
    logic           up;
    logic           ep;
  } snap_t;

  typedef struct {
    string name;
    snap_t snap;
    int    at_cycle;
  } exp_t;

  logic           clk = 1'b0;
  logic           nreset = 1'b1;
  logic [3:0]     key_code = 4'h0;
  logic           key_valid_n = 1'b1;
  logic [4*N-1:0] attempt;
  logic [CW-1:0]  digit_count;
  logic           locked;
  logic           set_mode;
  logic           lockout;
  logic [3:0]     fail_count;
  logic           unlock_pulse;
  logic           error_pulse;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  combo_lock_ctrl #(
    .NUM_DIGITS     (N),
    .MAX_TRIES      (MT),
    .LOCKOUT_CYCLES (LC),
    .CLR_KEY        (4'hF),
    .ENTER_KEY      (4'hE)
  ) dut (
    .MAX10_CLK1_50 (clk),
    .nreset        (nreset),
    .key_code      (key_code),
    .key_valid_n   (key_valid_n),
    .attempt       (attempt),
    .digit_count   (digit_count),
    .locked        (locked),
    .set_mode      (set_mode),
    .lockout       (lockout),
    .fail_count    (fail_count),
    .unlock_pulse  (unlock_pulse),
    .error_pulse   (error_pulse)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input bit ok, input string got, input string want);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %s, expected %s", name, got, want);
    end
  endtask

  function automatic string fmt(input snap_t s, input int c);
    return $sformatf("attempt=%h count=%0d locked=%b set=%b lockout=%b fail=%0d up=%b ep=%b @cyc %0d",
                     s.attempt, s.count, s.locked, s.set_mode, s.lockout, s.fail, s.up, s.ep, c);
  endfunction

  function automatic snap_t mk(input logic [4*N-1:0] a, input int c, input int st, input int f,
                               input bit up, input bit ep);
    snap_t s;
    s.attempt  = a;
    s.count    = CW'(c);
    s.locked   = (st != UNL);
    s.set_mode = (st == UNL);
    s.lockout  = (st == OUT);
    s.fail     = 4'(f);
    s.up       = up;
    s.ep       = ep;
    return s;
  endfunction

  task automatic push(input string name, input snap_t s, input int at);
    exp_t e;
    e.name = name;
    e.snap = s;
    e.at_cycle = at;
    sb.push_back(e);
  endtask

  // Called at a negedge; returns at a negedge. Valid low is first sampled at edge cyc+1.
  task automatic press(input logic [3:0] c, input int hold, input int gap);
    key_code = c;
    key_valid_n = 1'b0;
    repeat (hold) @(negedge clk);
    key_valid_n = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  // Data key whose only effect is one snapshot exactly four edges after the press.
  task automatic data_key(input logic [3:0] c, input logic [4*N-1:0] a, input int cnt,
                          input int st, input int f, input string name);
    push(name, mk(a, cnt, st, f, 1'b0, 1'b0), cyc + 1 + 4);
    press(c, 2, 6);
  endtask

  task automatic enter_code(input logic [4*N-1:0] v, input int st, input int f, input string tag);
    data_key(v[15:12], {v[15:12], 12'h000}, 1, st, f, {tag, "_d1"});
    data_key(v[11:8],  {v[15:8],  8'h00},   2, st, f, {tag, "_d2"});
    data_key(v[7:4],   {v[15:4],  4'h0},    3, st, f, {tag, "_d3"});
    data_key(v[3:0],   v,                   4, st, f, {tag, "_d4"});
  endtask

  always @(negedge clk) begin : monitor
    snap_t cur;
    snap_t prev;
    bit    have_prev;
    exp_t  e;
    cur = '{attempt: attempt, count: digit_count, locked: locked, set_mode: set_mode,
            lockout: lockout, fail: fail_count, up: unlock_pulse, ep: error_pulse};
    if (!have_prev || cur != prev) begin
      if (sb.size() == 0) begin
        check("unexpected_change", 1'b0, fmt(cur, cyc), "no output change");
      end else begin
        e = sb.pop_front();
        check(e.name, (cur == e.snap) && (e.at_cycle < 0 || e.at_cycle == cyc),
              fmt(cur, cyc), fmt(e.snap, e.at_cycle));
      end
    end
    prev = cur;
    have_prev = 1'b1;
  end

  initial begin : stim
    int k;
    exp_t e;
    push("reset_state", mk(0, 0, UNL, 0, 0, 0), -1);
    #1 nreset = 1'b0;
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    repeat (2) @(negedge clk);

    // Set the code 1234 from UNLOCKED.
    enter_code(16'h1234, UNL, 0, "set");
    k = cyc + 1;
    push("set_enter_locks", mk(0, 0, LCK, 0, 0, 0), k + 4);
    press(4'hE, 2, 6);

    // Correct code unlocks with a one-cycle pulse.
    enter_code(16'h1234, LCK, 0, "open");
    k = cyc + 1;
    push("unlock_pulse_hi", mk(0, 0, UNL, 0, 1, 0), k + 4);
    push("unlock_pulse_lo", mk(0, 0, UNL, 0, 0, 0), k + 5);
    press(4'hE, 2, 6);

    // Relock with 1234, then two wrong codes trigger a 20-cycle lockout.
    enter_code(16'h1234, UNL, 0, "reset");
    k = cyc + 1;
    push("relock_enter", mk(0, 0, LCK, 0, 0, 0), k + 4);
    press(4'hE, 2, 6);
    enter_code(16'h9999, LCK, 0, "bad1");
    k = cyc + 1;
    push("error1_hi", mk(0, 0, LCK, 1, 0, 1), k + 4);
    push("error1_lo", mk(0, 0, LCK, 1, 0, 0), k + 5);
    press(4'hE, 2, 6);
    enter_code(16'h9999, LCK, 1, "bad2");
    k = cyc + 1;
    push("lockout_entry", mk(0, 0, OUT, 2, 0, 1), k + 4);
    push("error2_lo", mk(0, 0, OUT, 2, 0, 0), k + 5);
    push("lockout_exit_after_20", mk(0, 0, LCK, 0, 0, 0), k + 4 + LC);
    press(4'hE, 2, 6);
    press(4'h7, 2, 6);
    while (cyc < k + 19) @(negedge clk);
    press(4'h7, 2, 6);
    repeat (4) @(negedge clk);

    // ENTER with a short entry is data; CLR empties the entry.
    data_key(4'hE, 16'hE000, 1, LCK, 0, "enter_as_data1");
    data_key(4'hE, 16'hEE00, 2, LCK, 0, "enter_as_data2");
    data_key(4'hF, 16'h0000, 0, LCK, 0, "clear_entry");

    // Long hold yields exactly one event at edge k+4.
    k = cyc + 1;
    push("long_hold_one_event", mk(16'h5000, 1, LCK, 0, 0, 0), k + 4);
    press(4'h5, 100, 6);
    data_key(4'hF, 16'h0000, 0, LCK, 0, "clear_after_hold");

    // Reset in the middle of a lockout, with a key held through reset release.
    enter_code(16'h9999, LCK, 0, "rbad1");
    k = cyc + 1;
    push("rerror1_hi", mk(0, 0, LCK, 1, 0, 1), k + 4);
    push("rerror1_lo", mk(0, 0, LCK, 1, 0, 0), k + 5);
    press(4'hE, 2, 6);
    enter_code(16'h9999, LCK, 1, "rbad2");
    k = cyc + 1;
    push("rlockout_entry", mk(0, 0, OUT, 2, 0, 1), k + 4);
    push("rerror2_lo", mk(0, 0, OUT, 2, 0, 0), k + 5);
    press(4'hE, 2, 6);
    @(posedge clk);
    #2;
    push("reset_mid_lockout", mk(0, 0, UNL, 0, 0, 0), cyc);
    nreset = 1'b0;
    @(negedge clk);
    key_code = 4'h3;
    key_valid_n = 1'b0;
    repeat (3) @(negedge clk);
    k = cyc + 1;
    push("held_through_reset", mk(16'h3000, 1, UNL, 0, 0, 0), k + 4);
    nreset = 1'b1;
    repeat (12) @(negedge clk);
    key_valid_n = 1'b1;
    repeat (6) @(negedge clk);

    for (int i = 0; i < 300 && sb.size() != 0; i++) @(negedge clk);
    repeat (30) @(negedge clk);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      check({e.name, "_missing"}, 1'b0, "no output change", fmt(e.snap, e.at_cycle));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
